// File: rtl/qua_lsp_arb_pkg.sv
// Shared constants for the Qua_Lsp basic-op arbiter: requester count,
// operand bundle geometry, bundle field offsets and FSM state encoding.
package qua_lsp_arb_pkg;

  localparam int NREQ     = 4;
  localparam int IDXW     = 2;
  localparam int BUNDLE_W = 256;

  // Field offsets inside one operand bundle (requesters pack, operators unpack).
  localparam int L_SUBA_OFS = 0;
  localparam int L_SUBB_OFS = 32;
  localparam int L_ADDA_OFS = 64;
  localparam int L_ADDB_OFS = 96;
  localparam int SUBA_OFS   = 128;
  localparam int SUBB_OFS   = 144;
  localparam int MULTA_OFS  = 160;
  localparam int MULTB_OFS  = 176;
  localparam int L_MACA_OFS = 192;
  localparam int L_MACB_OFS = 208;
  localparam int L_MACC_OFS = 224;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } state_e;

endpackage

// File: rtl/qua_lsp_math_arbiter_rr_pick.sv
// Rotating-priority search: first requester at or after ptr, modulo NREQ.
module qua_lsp_math_arbiter_rr_pick
  import qua_lsp_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDXW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/qua_lsp_math_arbiter.sv
// Round-robin arbiter that lends the shared basic-op unit set to one
// Qua_Lsp sub-block at a time, with ownership lock, a one-cycle drain
// gap between owners and a hold-time watchdog.
module qua_lsp_math_arbiter
  import qua_lsp_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          rel,
  input  logic [NREQ*BUNDLE_W-1:0] bundleIn,
  output logic [NREQ-1:0]          grant,
  output logic [IDXW-1:0]          owner,
  output logic                     busy,
  output logic [BUNDLE_W-1:0]      bundleOut,
  output logic                     timeoutErr
);

  localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic            timeout_q, timeout_d;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic            owner_release;
  logic            wd_hit;

  qua_lsp_math_arbiter_rr_pick u_rr_pick (
    .req   (req),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Release by the owner only: explicit rel pulse or dropping its request.
  assign owner_release = rel[owner_q] | ~req[owner_q];
  assign wd_hit        = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_release || wd_hit) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          rr_d      = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          timeout_d = wd_hit && !owner_release;
          state_d   = ST_HANDOVER;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_HANDOVER: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, ownership and watchdog registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      rr_q      <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Operands reach the shared units only while a grant is held; zero otherwise.
  assign bundleOut  = (state_q == ST_GRANT) ? bundleIn[int'(owner_q) * BUNDLE_W +: BUNDLE_W]
                                            : '0;
  assign grant      = grant_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign timeoutErr = timeout_q;

endmodule
